// File: rtl/fp32_div_pkg.sv
// Shared constants, FSM state encoding and operand classes for the fp32
// sequential divider.
package fp32_div_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          BIAS    = 127;
  localparam int          Q_BITS  = 25;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG  = 31'h7F80_0000;
  localparam logic [30:0] ZERO_MAG = 31'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RND  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // Denormals (exponent 0) are deliberately folded into the zero class.
  function automatic cls_t classify(input logic [31:0] x);
    if (x[30:23] == '0)                 return CLS_ZERO;
    else if (x[30:23] != EXP_MAX)       return CLS_NORM;
    else if (x[FRAC_W-1:0] == '0)       return CLS_INF;
    else                                return CLS_NAN;
  endfunction

endpackage

// File: rtl/fp32_div_mant_core.sv
// Radix-2 restoring significand divider: one quotient bit per step strobe.
// Shift-left-after-subtract keeps the remainder below 2*divisor (25 bits).
module fp32_div_mant_core
  import fp32_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [24:0] rem_init,
  input  logic [23:0] divisor,
  output logic [24:0] q,
  output logic        sticky,
  output logic        last
);

  logic [24:0] rem_q, rem_d;
  logic [24:0] q_q, q_d;
  logic [23:0] mb_q, mb_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] diff;

  always_comb begin
    rem_d = rem_q;
    q_d   = q_q;
    mb_d  = mb_q;
    cnt_d = cnt_q;
    diff  = rem_q - {1'b0, mb_q};
    if (load) begin
      rem_d = rem_init;
      q_d   = '0;
      mb_d  = divisor;
      cnt_d = '0;
    end else if (step) begin
      if (rem_q >= {1'b0, mb_q}) begin
        q_d   = {q_q[23:0], 1'b1};
        rem_d = {diff[23:0], 1'b0};
      end else begin
        q_d   = {q_q[23:0], 1'b0};
        rem_d = {rem_q[23:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      q_q   <= '0;
      mb_q  <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      q_q   <= q_d;
      mb_q  <= mb_d;
      cnt_q <= cnt_d;
    end
  end

  assign q      = q_q;
  assign sticky = (rem_q != '0);
  assign last   = (cnt_q == 5'(Q_BITS - 1));

endmodule

// File: rtl/fp32_seq_divider.sv
// Iterative fp32 divider top: handshake FSM, operand classification,
// exponent prescale and round-to-nearest-even pack.
module fp32_seq_divider
  import fp32_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] C,
  output logic        error_flag,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; valid, once raised, is held with stable data until that edge.
  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        c_q, c_d;
  logic               err_q, err_d;
  logic               sign_q, sign_d;
  cls_t               cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic signed [9:0]  exp_q, exp_d;

  logic [23:0]        ma, mb;
  logic               pre_lt;
  logic [24:0]        rem_init;
  logic               load, step, last, sticky;
  logic [24:0]        q;

  logic               rnd_up, carry;
  logic [24:0]        mant_sum;
  logic [22:0]        frac;
  logic signed [9:0]  exp_r;
  logic [31:0]        res_c;
  logic               res_err;

  assign ma       = {1'b1, A[FRAC_W-1:0]};
  assign mb       = {1'b1, B[FRAC_W-1:0]};
  assign pre_lt   = (ma < mb);
  assign rem_init = pre_lt ? {ma, 1'b0} : {1'b0, ma};

  fp32_div_mant_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .rem_init (rem_init),
    .divisor  (mb),
    .q        (q),
    .sticky   (sticky),
    .last     (last)
  );

  // q[24] is the integer bit, q[23:1] the fraction, q[0] the guard bit.
  always_comb begin
    rnd_up   = q[0] & (sticky | q[1]);
    mant_sum = {1'b0, q[24:1]} + {24'd0, rnd_up};
    carry    = mant_sum[24];
    frac     = carry ? mant_sum[23:1] : mant_sum[22:0];
    exp_r    = exp_q + {9'd0, carry};
    res_c    = {sign_q, exp_r[7:0], frac};
    res_err  = 1'b0;
    if (cls_a_q == CLS_NAN || cls_b_q == CLS_NAN ||
        (cls_a_q == CLS_ZERO && cls_b_q == CLS_ZERO) ||
        (cls_a_q == CLS_INF && cls_b_q == CLS_INF)) begin
      res_c   = QNAN;
      res_err = 1'b1;
    end else if (cls_a_q == CLS_INF) begin
      res_c = {sign_q, INF_MAG};
    end else if (cls_b_q == CLS_ZERO) begin
      res_c   = {sign_q, INF_MAG};
      res_err = 1'b1;
    end else if (cls_a_q == CLS_ZERO || cls_b_q == CLS_INF) begin
      res_c = {sign_q, ZERO_MAG};
    end else if (exp_r >= 10'sd255) begin
      res_c   = {sign_q, INF_MAG};
      res_err = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      res_c   = {sign_q, ZERO_MAG};
      res_err = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    err_d       = err_q;
    sign_d      = sign_q;
    cls_a_d     = cls_a_q;
    cls_b_d     = cls_b_q;
    exp_d       = exp_q;
    load        = 1'b0;
    step        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          sign_d     = A[31] ^ B[31];
          cls_a_d    = classify(A);
          cls_b_d    = classify(B);
          exp_d      = {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'(BIAS)
                       - {9'd0, pre_lt};
          in_ready_d = 1'b0;
          state_d    = S_DIV;
        end
      end
      S_DIV: begin
        step = 1'b1;
        if (last) state_d = S_RND;
      end
      S_RND: begin
        c_d         = res_c;
        err_d       = res_err;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      err_q       <= 1'b0;
      sign_q      <= 1'b0;
      cls_a_q     <= CLS_ZERO;
      cls_b_q     <= CLS_ZERO;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      err_q       <= err_d;
      sign_q      <= sign_d;
      cls_a_q     <= cls_a_d;
      cls_b_q     <= cls_b_d;
      exp_q       <= exp_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign C          = c_q;
  assign error_flag = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Directed and randomised-order checks of fp32_seq_divider against a table of
// hand-derived quotients, with an expected-result queue.
module tb_fp32_seq_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] C;
  logic        error_flag;
  logic [1:0]  dbg_state;

  logic [32:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  localparam int N_VEC = 16;
  logic [31:0] va [N_VEC];
  logic [31:0] vb [N_VEC];
  logic [31:0] vc [N_VEC];
  logic        ve [N_VEC];

  fp32_seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .C          (C),
    .error_flag (error_flag),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    va[0]  = 32'h3FC00000; vb[0]  = 32'h3FC00000; vc[0]  = 32'h3F800000; ve[0]  = 1'b0;
    va[1]  = 32'h42C80000; vb[1]  = 32'h40800000; vc[1]  = 32'h41C80000; ve[1]  = 1'b0;
    va[2]  = 32'h3F800000; vb[2]  = 32'h40400000; vc[2]  = 32'h3EAAAAAB; ve[2]  = 1'b0;
    va[3]  = 32'h3F800000; vb[3]  = 32'h00000000; vc[3]  = 32'h7F800000; ve[3]  = 1'b1;
    va[4]  = 32'h00000000; vb[4]  = 32'h00000000; vc[4]  = 32'h7FC00000; ve[4]  = 1'b1;
    va[5]  = 32'h7F800000; vb[5]  = 32'h7F800000; vc[5]  = 32'h7FC00000; ve[5]  = 1'b1;
    va[6]  = 32'h7F000000; vb[6]  = 32'h3E800000; vc[6]  = 32'h7F800000; ve[6]  = 1'b1;
    va[7]  = 32'h00800000; vb[7]  = 32'h40800000; vc[7]  = 32'h00000000; ve[7]  = 1'b1;
    va[8]  = 32'hC0400000; vb[8]  = 32'h40000000; vc[8]  = 32'hBFC00000; ve[8]  = 1'b0;
    va[9]  = 32'h40000000; vb[9]  = 32'h40400000; vc[9]  = 32'h3F2AAAAB; ve[9]  = 1'b0;
    va[10] = 32'h7F800000; vb[10] = 32'h40000000; vc[10] = 32'h7F800000; ve[10] = 1'b0;
    va[11] = 32'hC0000000; vb[11] = 32'h7F800000; vc[11] = 32'h80000000; ve[11] = 1'b0;
    va[12] = 32'h7FC00000; vb[12] = 32'h3F800000; vc[12] = 32'h7FC00000; ve[12] = 1'b1;
    va[13] = 32'hC0000000; vb[13] = 32'h00000000; vc[13] = 32'hFF800000; ve[13] = 1'b1;
    va[14] = 32'h00000000; vb[14] = 32'hC0000000; vc[14] = 32'h80000000; ve[14] = 1'b0;
    va[15] = 32'hFF800000; vb[15] = 32'h00000000; vc[15] = 32'hFF800000; ve[15] = 1'b0;
  end

  // driver + scoreboard for one operation; optional back-pressure and
  // stray in_valid while the result is held
  task automatic do_op(input int idx, input int hold, input bit poke, input string name);
    int          cyc;
    logic [32:0] exp_v;
    logic [31:0] c0;
    logic        e0;
    bit          stable;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_wait actual=%b required=1", name, in_ready);
    else n_pass++;
    A = va[idx];
    B = vb[idx];
    in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back({ve[idx], vc[idx]});
    #1 in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (cyc !== 26) $display("FAIL %s latency actual=%0d required=26", name, cyc);
    else n_pass++;
    c0 = C;
    e0 = error_flag;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        A = 32'h40000000;
        B = 32'h3F800000;
        in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || C !== c0 || error_flag !== e0 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      n_checks++;
      if (!stable) $display("FAIL %s hold_stable actual=0 required=1", name);
      else n_pass++;
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (C !== exp_v[31:0]) $display("FAIL %s C actual=%h required=%h", name, C, exp_v[31:0]);
    else n_pass++;
    n_checks++;
    if (error_flag !== exp_v[32]) $display("FAIL %s err actual=%b required=%b", name, error_flag, exp_v[32]);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release actual=%b%b required=01", name, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || C !== 32'h0 || error_flag !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL reset_state actual=%b%b_%h_%b_%0d required=10_00000000_0_0",
               in_ready, out_valid, C, error_flag, dbg_state);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_op(0, 0, 1'b0, "div_1p5_1p5");
    do_op(1, 1, 1'b0, "div_100_4");
    do_op(2, 0, 1'b0, "div_1_3_rne");
    do_op(9, 0, 1'b0, "div_2_3");
    do_op(8, 0, 1'b0, "div_neg3_2");
  endtask

  task automatic test_special();
    for (int i = 3; i <= 5; i++) do_op(i, 0, 1'b0, $sformatf("special%0d", i));
    for (int i = 10; i < N_VEC; i++) do_op(i, 0, 1'b0, $sformatf("special%0d", i));
  endtask

  task automatic test_range();
    do_op(6, 0, 1'b0, "overflow");
    do_op(7, 0, 1'b0, "underflow");
  endtask

  task automatic test_backpressure();
    do_op(1, 10, 1'b1, "backpressure");
    // the stray request made while held must not have been taken
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_ignored actual=%0d_%b%b required=0_10", dbg_state, in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    A = va[2];
    B = vb[2];
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== 2'd0)
      $display("FAIL midop_reset actual=%b%b_%0d required=01_0", out_valid, in_ready, dbg_state);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_op(8, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      do_op($urandom_range(0, N_VEC - 1), $urandom_range(0, 3), 1'b0, $sformatf("b2b%0d", k));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_basic();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
